mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Parametrised memory stage for the 5-stage pipeline with a load/store unit and a variable-latency data-memory handshake. Generates byte-enabled stores, sign/zero-extended byte/half/word loads, misalignment detection and a pipeline stall, then registers results into the M/W pipeline register. Sits between the execute register and writeback. Replaces the fixed single-cycle internal RAM with an external request/grant/response port.

## Interface
- WORD, 32: datapath width; multiple of 8, 32 or 64
- REG_SIZE, 5: register-index width
- ADDR_W, 32: dmem_addr width
- BE_W, WORD/8: byte-enable width (derived, not overridden)
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- validM  in  1  instruction in M is valid
- ALUResultM  in  WORD  byte address / ALU result
- writeDataM  in  WORD  store data (LSB-aligned)
- writeRegM  in  REG_SIZE  destination register
- regWriteM, memWriteM, mem2regM, finishM, zeroM, branchM  in  1 each  control
- sizeM  in  2  00 byte, 01 half, 10 32-bit, 11 full WORD
- unsignedM  in  1  zero-extend loads
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  ADDR_W  ALUResultM with low log2(BE_W) bits cleared
- dmem_be  out  BE_W  byte enables
- dmem_wdata  out  WORD  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  WORD  load data
- stallM  out  1  hold fetch/decode/execute and M inputs
- PCSrcM  out  1  validM & zeroM & branchM
- misalignM  out  1  misaligned access detected this cycle
- validW, misalignW, regWriteW, mem2regW, memWriteW, finishW  out  1 each  registered
- readDataW, ALUResultW  out  WORD  registered
- writeRegW  out  REG_SIZE  registered

## Operation
- memop = validM & (mem2regM | memWriteM) & ~misalignM.
- Misaligned: half with addr[0]≠0; 32-bit with addr[1:0]≠0; full with any low bit set; size 10 on WORD=32 is legal and identical to 11. Misaligned op issues no request, enters W as validW=1, misalignW=1, regWriteW=0, memWriteW=0.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: non-memop passes in one cycle. memop asserts dmem_req. Store with gnt → complete. Load with gnt → WAIT. No gnt → REQ.
  - REQ: dmem_req held; gnt on store → complete, IDLE; gnt on load → WAIT.
  - WAIT: dmem_req=0; rvalid → complete, IDLE.
- stallM = memop & ~complete, combinational.
- W register loads M fields on non-stalled cycles; while stalled it loads a bubble (all fields 0).
- Store lanes: byte be=1<<off, wdata = byte replicated; half be=0b11<<off, halfword replicated; 32-bit on WORD=64 be=0x0F<<off; full be all ones.
- Load: shift dmem_rdata right by off*8, then extract size bits; sign-extend unless unsignedM. readDataW = extended value; ALUResultW = ALUResultM.
- dmem_rvalid outside WAIT and dmem_gnt outside IDLE/REQ are ignored.

## Timing
- Reset: state IDLE; all W outputs 0; dmem_req 0 while reset high. Reset mid-transaction abandons it; a late rvalid is ignored.
- Store with gnt in IDLE: zero stall cycles.
- Load: minimum one stall cycle. Data appears on readDataW on the edge after the rvalid cycle.
- dmem_addr/be/wdata/we are combinational from M inputs and stable while stallM=1, because upstream holds M.
- rvalid is never accepted in the same cycle as gnt.
- misalignM and PCSrcM are combinational. They are gated by validM only, not by state.

## Structure
- Package lsu_pkg: size encoding localparams, state enum {IDLE, REQ, WAIT}, and function be_width(WORD).
- Sub-module lsu_align: combinational byte-enable, store-lane and load-extract logic; parametrised by WORD.
- FSM, stall logic and the async-reset W register live in the top level.

## Test plan
- Word store at 0x100, data 0xDEADBEEF, gnt same cycle -> dmem_be=0xF, addr 0x100, stallM=0, next cycle validW=1, memWriteW=1.
- Byte load at 0x103, rdata 0x80xxxxxx, unsignedM=0, gnt in cycle 0, rvalid in cycle 3 -> stallM high cycles 0–2, readDataW=0xFFFFFF80; repeat with unsignedM=1 -> 0x00000080.
- Half store at 0x202, data 0x1234, gnt delayed 2 cycles -> state REQ for 2 cycles, be=0xC, wdata=0x12341234, stallM=1 for 2 cycles, W bubbles meanwhile.
- Half load at 0x201 -> misalignM=1, dmem_req=0, next W misalignW=1, regWriteW=0.
- Reset asserted during WAIT, rvalid 1 cycle after release -> state IDLE, W outputs all 0, no load retired.
- WORD=64: 32-bit load at 0x104 with rdata 0x7FFFFFFF_00000000 -> be ignored on load, readDataW=0x00000000_7FFFFFFF.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit: access sizes,
// handshake FSM states and the byte-enable width helper.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // 32-bit access
  localparam logic [1:0] SZ_FULL = 2'b11;  // full datapath width

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } lsu_state_e;

  function automatic int be_width(input int word);
    return word / 8;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, shift/extend for loads and the alignment
// check for the current access size. Purely combinational.
module lsu_align
  import lsu_pkg::*;
#(
  parameter  int WORD  = 32,
  localparam int BE_W  = WORD / 8,
  localparam int OFF_W = $clog2(BE_W)
) (
  input  logic [OFF_W-1:0] off,
  input  logic [1:0]       size,
  input  logic             unsigned_ld,
  input  logic [WORD-1:0]  st_data,
  input  logic [WORD-1:0]  ld_data,
  output logic [BE_W-1:0]  be,
  output logic [WORD-1:0]  st_lanes,
  output logic [WORD-1:0]  ld_ext,
  output logic             misalign
);

  logic [WORD-1:0] shifted;
  logic [WORD-1:0] mask;
  logic            sign;

  always_comb begin
    be       = '0;
    st_lanes = '0;
    mask     = '0;
    sign     = 1'b0;
    misalign = 1'b0;
    shifted  = ld_data >> {off, 3'b000};
    case (size)
      SZ_BYTE: begin
        be       = BE_W'(1) << off;
        st_lanes = {BE_W{st_data[7:0]}};
        mask     = WORD'(8'hFF);
        sign     = shifted[7];
      end
      SZ_HALF: begin
        be       = BE_W'(2'b11) << off;
        st_lanes = {(BE_W/2){st_data[15:0]}};
        mask     = WORD'(16'hFFFF);
        sign     = shifted[15];
        misalign = off[0];
      end
      SZ_WORD: begin
        // On a 32-bit datapath this collapses to the full-width case.
        be       = BE_W'(4'hF) << off;
        st_lanes = {(BE_W/4){st_data[31:0]}};
        mask     = WORD'(32'hFFFF_FFFF);
        sign     = shifted[31];
        misalign = |off[1:0];
      end
      default: begin
        be       = '1;
        st_lanes = st_data;
        mask     = '1;
        sign     = shifted[WORD-1];
        misalign = |off;
      end
    endcase
    ld_ext = (shifted & mask) | ({WORD{sign & ~unsigned_ld}} & ~mask);
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage: drives the external data-memory request/grant/response port,
// stalls upstream until the access completes and registers results into M/W.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int WORD     = 32,
  parameter int REG_SIZE = 5,
  parameter int ADDR_W   = 32,
  parameter int BE_W     = be_width(WORD)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                validM,
  input  logic [WORD-1:0]     ALUResultM,
  input  logic [WORD-1:0]     writeDataM,
  input  logic [REG_SIZE-1:0] writeRegM,
  input  logic                regWriteM,
  input  logic                memWriteM,
  input  logic                mem2regM,
  input  logic                finishM,
  input  logic                zeroM,
  input  logic                branchM,
  input  logic [1:0]          sizeM,
  input  logic                unsignedM,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [BE_W-1:0]     dmem_be,
  output logic [WORD-1:0]     dmem_wdata,
  input  logic                dmem_gnt,
  input  logic                dmem_rvalid,
  input  logic [WORD-1:0]     dmem_rdata,
  output logic                stallM,
  output logic                PCSrcM,
  output logic                misalignM,
  output logic                validW,
  output logic                misalignW,
  output logic                regWriteW,
  output logic                mem2regW,
  output logic                memWriteW,
  output logic                finishW,
  output logic [WORD-1:0]     readDataW,
  output logic [WORD-1:0]     ALUResultW,
  output logic [REG_SIZE-1:0] writeRegW
);

  localparam int OFF_W = $clog2(BE_W);

  lsu_state_e          state_q, state_d;
  logic                memop, complete, misal_raw;
  logic [WORD-1:0]     ld_ext;

  logic                validw_q, validw_d, misalignw_q, misalignw_d;
  logic                regwritew_q, regwritew_d, mem2regw_q, mem2regw_d;
  logic                memwritew_q, memwritew_d, finishw_q, finishw_d;
  logic [WORD-1:0]     readdataw_q, readdataw_d, aluresultw_q, aluresultw_d;
  logic [REG_SIZE-1:0] writeregw_q, writeregw_d;

  lsu_align #(.WORD(WORD)) u_align (
    .off         (ALUResultM[OFF_W-1:0]),
    .size        (sizeM),
    .unsigned_ld (unsignedM),
    .st_data     (writeDataM),
    .ld_data     (dmem_rdata),
    .be          (dmem_be),
    .st_lanes    (dmem_wdata),
    .ld_ext      (ld_ext),
    .misalign    (misal_raw)
  );

  // Alignment only matters for memory ops; FSM state plays no part.
  assign misalignM = validM & (mem2regM | memWriteM) & misal_raw;
  assign memop     = validM & (mem2regM | memWriteM) & ~misalignM;
  assign PCSrcM    = validM & zeroM & branchM;
  assign dmem_we   = memWriteM;
  assign dmem_addr = ADDR_W'(ALUResultM) & ~ADDR_W'(BE_W - 1);
  assign stallM    = memop & ~complete;

  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    dmem_req = 1'b0;
    case (state_q)
      IDLE: if (memop) begin
        dmem_req = 1'b1;
        if (!dmem_gnt)      state_d  = REQ;
        else if (memWriteM) complete = 1'b1;
        else                state_d  = WAIT;
      end
      REQ: begin
        dmem_req = memop;
        if (memop && dmem_gnt) begin
          if (memWriteM) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d  = WAIT;
          end
        end
      end
      WAIT: if (dmem_rvalid) begin
        complete = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    dmem_req = dmem_req & ~reset;
  end

  // Stalled cycles push a bubble into W; misaligned ops retire with no side effects.
  always_comb begin
    validw_d     = 1'b0;
    misalignw_d  = 1'b0;
    regwritew_d  = 1'b0;
    mem2regw_d   = 1'b0;
    memwritew_d  = 1'b0;
    finishw_d    = 1'b0;
    readdataw_d  = '0;
    aluresultw_d = '0;
    writeregw_d  = '0;
    if (!stallM) begin
      validw_d     = validM;
      misalignw_d  = misalignM;
      regwritew_d  = regWriteM & ~misalignM;
      mem2regw_d   = mem2regM;
      memwritew_d  = memWriteM & ~misalignM;
      finishw_d    = finishM;
      readdataw_d  = (memop && !memWriteM) ? ld_ext : '0;
      aluresultw_d = ALUResultM;
      writeregw_d  = writeRegM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      validw_q     <= 1'b0;
      misalignw_q  <= 1'b0;
      regwritew_q  <= 1'b0;
      mem2regw_q   <= 1'b0;
      memwritew_q  <= 1'b0;
      finishw_q    <= 1'b0;
      readdataw_q  <= '0;
      aluresultw_q <= '0;
      writeregw_q  <= '0;
    end else begin
      state_q      <= state_d;
      validw_q     <= validw_d;
      misalignw_q  <= misalignw_d;
      regwritew_q  <= regwritew_d;
      mem2regw_q   <= mem2regw_d;
      memwritew_q  <= memwritew_d;
      finishw_q    <= finishw_d;
      readdataw_q  <= readdataw_d;
      aluresultw_q <= aluresultw_d;
      writeregw_q  <= writeregw_d;
    end
  end

  assign validW     = validw_q;
  assign misalignW  = misalignw_q;
  assign regWriteW  = regwritew_q;
  assign mem2regW   = mem2regw_q;
  assign memWriteW  = memwritew_q;
  assign finishW    = finishw_q;
  assign readDataW  = readdataw_q;
  assign ALUResultW = aluresultw_q;
  assign writeRegW  = writeregw_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a 32-bit instance for the main sequence
// and a 64-bit instance for lane steering on the wide datapath.
module tb_mem_stage_lsu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        validM, regWriteM, memWriteM, mem2regM, finishM, zeroM, branchM, unsignedM;
  logic [31:0] ALUResultM, writeDataM, dmem_rdata;
  logic [4:0]  writeRegM;
  logic [1:0]  sizeM;
  logic        dmem_gnt, dmem_rvalid;
  logic        dmem_req, dmem_we, stallM, PCSrcM, misalignM;
  logic [31:0] dmem_addr, dmem_wdata, readDataW, ALUResultW;
  logic [3:0]  dmem_be;
  logic        validW, misalignW, regWriteW, mem2regW, memWriteW, finishW;
  logic [4:0]  writeRegW;

  // 64-bit instance
  logic        b_validM, b_mem2regM, b_memWriteM, b_gnt, b_rvalid;
  logic [1:0]  b_sizeM;
  logic [63:0] b_ALUResultM, b_writeDataM, b_rdata;
  logic        b_req, b_we, b_stall, b_pcsrc, b_mis;
  logic [31:0] b_addr;
  logic [7:0]  b_be;
  logic [63:0] b_wdata, b_rdW, b_aluW;
  logic        b_vW, b_misW, b_rwW, b_m2rW, b_mwW, b_finW;
  logic [4:0]  b_wrW;

  mem_stage_lsu #(.WORD(32), .REG_SIZE(5), .ADDR_W(32)) u0 (
    .clk(clk), .reset(reset), .validM(validM), .ALUResultM(ALUResultM),
    .writeDataM(writeDataM), .writeRegM(writeRegM), .regWriteM(regWriteM),
    .memWriteM(memWriteM), .mem2regM(mem2regM), .finishM(finishM), .zeroM(zeroM),
    .branchM(branchM), .sizeM(sizeM), .unsignedM(unsignedM), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .stallM(stallM), .PCSrcM(PCSrcM), .misalignM(misalignM), .validW(validW),
    .misalignW(misalignW), .regWriteW(regWriteW), .mem2regW(mem2regW),
    .memWriteW(memWriteW), .finishW(finishW), .readDataW(readDataW),
    .ALUResultW(ALUResultW), .writeRegW(writeRegW)
  );

  mem_stage_lsu #(.WORD(64), .REG_SIZE(5), .ADDR_W(32)) u1 (
    .clk(clk), .reset(reset), .validM(b_validM), .ALUResultM(b_ALUResultM),
    .writeDataM(b_writeDataM), .writeRegM(5'd0), .regWriteM(1'b0),
    .memWriteM(b_memWriteM), .mem2regM(b_mem2regM), .finishM(1'b0), .zeroM(1'b0),
    .branchM(1'b0), .sizeM(b_sizeM), .unsignedM(1'b0), .dmem_req(b_req),
    .dmem_we(b_we), .dmem_addr(b_addr), .dmem_be(b_be), .dmem_wdata(b_wdata),
    .dmem_gnt(b_gnt), .dmem_rvalid(b_rvalid), .dmem_rdata(b_rdata),
    .stallM(b_stall), .PCSrcM(b_pcsrc), .misalignM(b_mis), .validW(b_vW),
    .misalignW(b_misW), .regWriteW(b_rwW), .mem2regW(b_m2rW),
    .memWriteW(b_mwW), .finishW(b_finW), .readDataW(b_rdW),
    .ALUResultW(b_aluW), .writeRegW(b_wrW)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_clr();
    validM = 0; regWriteM = 0; memWriteM = 0; mem2regM = 0; finishM = 0;
    zeroM = 0; branchM = 0; unsignedM = 0; sizeM = 0; writeRegM = 0;
    ALUResultM = 0; writeDataM = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
  endtask

  task automatic m_op(input logic ld, input logic st, input logic [1:0] sz,
                      input logic [31:0] addr, input logic [31:0] data,
                      input logic uns, input logic [4:0] rd);
    validM = 1; mem2regM = ld; regWriteM = ld; memWriteM = st; sizeM = sz;
    ALUResultM = addr; writeDataM = data; unsignedM = uns; writeRegM = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    m_clr();
    b_validM = 0; b_mem2regM = 0; b_memWriteM = 0; b_gnt = 0; b_rvalid = 0;
    b_sizeM = 0; b_ALUResultM = 0; b_writeDataM = 0; b_rdata = 0;
    reset = 1;

    // Reset: request suppressed even with a store presented
    @(negedge clk);
    m_op(0, 1, 2'b10, 32'h100, 32'hDEADBEEF, 0, 0); dmem_gnt = 1; #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_validW", validW, 0);
    chk("rst_readDataW", readDataW, 0);
    chk("rst_ALUResultW", ALUResultW, 0);

    // Word store, granted immediately
    @(negedge clk); reset = 0; #1;
    chk("sw_req", dmem_req, 1);
    chk("sw_we", dmem_we, 1);
    chk("sw_be", dmem_be, 4'hF);
    chk("sw_addr", dmem_addr, 32'h100);
    chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    chk("sw_stall", stallM, 0);
    @(negedge clk);
    chk("sw_validW", validW, 1);
    chk("sw_memWriteW", memWriteW, 1);
    chk("sw_regWriteW", regWriteW, 0);

    // Signed byte load at 0x103, gnt cycle 0, rvalid cycle 3
    m_op(1, 0, 2'b00, 32'h103, 0, 0, 5'd5); dmem_gnt = 1; #1;
    chk("lb_c0_stall", stallM, 1);
    chk("lb_c0_req", dmem_req, 1);
    @(negedge clk); dmem_gnt = 0; #1;
    chk("lb_c1_stall", stallM, 1);
    chk("lb_c1_req", dmem_req, 0);
    chk("lb_c1_bubble", validW, 0);
    @(negedge clk); #1;
    chk("lb_c2_stall", stallM, 1);
    @(negedge clk); dmem_rvalid = 1; dmem_rdata = 32'h80123456; #1;
    chk("lb_c3_stall", stallM, 0);
    @(negedge clk); dmem_rvalid = 0;
    chk("lb_readDataW", readDataW, 32'hFFFFFF80);
    chk("lb_validW", validW, 1);
    chk("lb_regWriteW", regWriteW, 1);
    chk("lb_mem2regW", mem2regW, 1);
    chk("lb_writeRegW", writeRegW, 5'd5);
    chk("lb_ALUResultW", ALUResultW, 32'h103);

    // Unsigned repeat; rvalid alongside gnt must not complete
    m_op(1, 0, 2'b00, 32'h103, 0, 1, 5'd6); dmem_gnt = 1; dmem_rvalid = 1; #1;
    chk("lbu_c0_stall", stallM, 1);
    @(negedge clk); dmem_gnt = 0; #1;
    chk("lbu_c1_stall", stallM, 0);
    @(negedge clk); dmem_rvalid = 0;
    chk("lbu_readDataW", readDataW, 32'h00000080);
    chk("lbu_writeRegW", writeRegW, 5'd6);

    // Half store at 0x202, grant held off two cycles
    m_op(0, 1, 2'b01, 32'h202, 32'h00001234, 0, 0); dmem_gnt = 0; #1;
    chk("sh_be", dmem_be, 4'hC);
    chk("sh_wdata", dmem_wdata, 32'h12341234);
    chk("sh_c0_stall", stallM, 1);
    chk("sh_c0_req", dmem_req, 1);
    @(negedge clk); #1;
    chk("sh_c1_stall", stallM, 1);
    chk("sh_c1_req", dmem_req, 1);
    chk("sh_c1_bubble", validW, 0);
    @(negedge clk); dmem_gnt = 1; #1;
    chk("sh_c2_stall", stallM, 0);
    chk("sh_c2_bubble", validW, 0);
    @(negedge clk); dmem_gnt = 0;
    chk("sh_validW", validW, 1);
    chk("sh_memWriteW", memWriteW, 1);

    // Misaligned half load
    m_op(1, 0, 2'b01, 32'h201, 0, 0, 5'd7); #1;
    chk("mis_flag", misalignM, 1);
    chk("mis_req", dmem_req, 0);
    chk("mis_stall", stallM, 0);
    @(negedge clk);
    chk("mis_validW", validW, 1);
    chk("mis_misalignW", misalignW, 1);
    chk("mis_regWriteW", regWriteW, 0);
    chk("mis_memWriteW", memWriteW, 0);

    // Branch resolution and plain ALU pass-through
    m_clr(); validM = 1; zeroM = 1; branchM = 1; #1;
    chk("pcsrc_taken", PCSrcM, 1);
    validM = 0; #1;
    chk("pcsrc_invalid", PCSrcM, 0);
    m_clr(); validM = 1; regWriteM = 1; ALUResultM = 32'h55; writeRegM = 5'd9; #1;
    chk("alu_stall", stallM, 0);
    @(negedge clk);
    chk("alu_validW", validW, 1);
    chk("alu_ALUResultW", ALUResultW, 32'h55);
    chk("alu_writeRegW", writeRegW, 5'd9);
    chk("alu_readDataW", readDataW, 0);

    // Reset during WAIT; late rvalid must not retire anything
    m_op(1, 0, 2'b10, 32'h100, 0, 0, 5'd3); dmem_gnt = 1; #1;
    chk("rw_c0_stall", stallM, 1);
    @(negedge clk); dmem_gnt = 0; reset = 1; #1;
    chk("rw_req", dmem_req, 0);
    chk("rw_validW", validW, 0);
    @(negedge clk); reset = 0; m_clr(); #1;
    chk("rw_post_stall", stallM, 0);
    @(negedge clk); dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D; #1;
    chk("rw_late_stall", stallM, 0);
    chk("rw_late_req", dmem_req, 0);
    @(negedge clk); dmem_rvalid = 0;
    chk("rw_late_validW", validW, 0);
    chk("rw_late_readDataW", readDataW, 0);
    chk("rw_late_regWriteW", regWriteW, 0);

    // 64-bit datapath: byte store lane steering
    b_validM = 1; b_memWriteM = 1; b_sizeM = 2'b00; b_ALUResultM = 64'h105;
    b_writeDataM = 64'hAB; b_gnt = 1; #1;
    chk("w64_sb_be", b_be, 8'h20);
    chk("w64_sb_wdata", b_wdata, 64'hABABABABABABABAB);
    chk("w64_sb_addr", b_addr, 32'h100);
    chk("w64_sb_stall", b_stall, 0);

    // 64-bit datapath: 32-bit load at 0x104
    @(negedge clk);
    b_memWriteM = 0; b_mem2regM = 1; b_sizeM = 2'b10; b_ALUResultM = 64'h104; b_gnt = 1; #1;
    chk("w64_lw_mis", b_mis, 0);
    chk("w64_lw_be", b_be, 8'hF0);
    chk("w64_lw_c0_stall", b_stall, 1);
    @(negedge clk); b_gnt = 0; b_rvalid = 1; b_rdata = 64'h7FFFFFFF_00000000; #1;
    chk("w64_lw_c1_stall", b_stall, 0);
    @(negedge clk); b_rvalid = 0;
    chk("w64_lw_readDataW", b_rdW, 64'h00000000_7FFFFFFF);
    chk("w64_lw_validW", b_vW, 1);
    b_ALUResultM = 64'h102; #1;
    chk("w64_lw_misalign", b_mis, 1);
    b_validM = 0; b_mem2regM = 0;

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
